// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle controller: opcode encodings,
// register-file write-source encodings, the sequencer state enum and the
// instruction classes produced when the latched fields are decoded.
// Opcode constants are 4 bits wide and right-aligned. A wider opcode field
// with any upper bit set is treated as an unknown opcode.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // Opcode encodings (lower four bits of the opcode field)
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_JUMP   = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_EPAR   = 4'b0101;
  localparam logic [3:0] OP_CP     = 4'b0111;
  localparam logic [3:0] OP_HALT   = 4'b1011;

  // Register-file write-source select. WRITE_MEM doubles as the idle value
  // because writeSrc must read 00 whenever regWrite is low.
  localparam logic [1:0] WRITE_MEM = 2'b00;
  localparam logic [1:0] WRITE_IMM = 2'b01;
  localparam logic [1:0] WRITE_RES = 2'b10;
  localparam logic [1:0] WRITE_ALU = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALTED
  } state_t;

  // What the controller does with an instruction once it is decoded.
  // cp is split by direction so EXEC needs no further look at sign.
  typedef enum logic [3:0] {
    CLS_IMM,
    CLS_ALU,
    CLS_CPOUT,
    CLS_CPIN,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_EPAR,
    CLS_STORE,
    CLS_HALT
  } instr_class_t;

  // Map the instruction fields to a class. The res/immediate format and any
  // opcode that is not recognised both end up as an immediate write.
  function automatic instr_class_t classifyInstr(
    input logic       format,
    input logic       opInRange,
    input logic [3:0] op,
    input logic       sign
  );
    instr_class_t cls;
    cls = CLS_IMM;
    if (format && opInRange) begin
      case (op)
        OP_ADD:    cls = CLS_ALU;
        OP_LOAD:   cls = CLS_LOAD;
        OP_STORE:  cls = CLS_STORE;
        OP_JUMP:   cls = CLS_JUMP;
        OP_BRANCH: cls = CLS_BRANCH;
        OP_EPAR:   cls = CLS_EPAR;
        OP_CP:     cls = sign ? CLS_CPOUT : CLS_CPIN;
        OP_HALT:   cls = CLS_HALT;
        default:   cls = CLS_IMM;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// ---------------------------------------------------------------------------
// ctrl_timeout
// Counts the cycles the controller spends waiting in MEM for a data memory
// acknowledge. o_expire is raised during the waiting cycle whose increment
// would bring the count to LIMIT, so a run of LIMIT un-acked MEM cycles
// expires on the last of them.
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset, clears the count
//   i_clear   return the count to zero (wins over i_enable)
//   i_enable  a waiting cycle; count advances by one
//   o_expire  this waiting cycle is the LIMIT-th
// ---------------------------------------------------------------------------
module ctrl_timeout #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  // Wait counter; clearing has priority so leaving MEM always starts the
  // next access from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC [-> MEM -> WB].
// Sits between the instruction register decode fields and the datapath
// enables. All outputs are registers, so every input is seen one clock
// after it is sampled and no input reaches an output combinationally.
//
// Cycle pattern of a single-cycle instruction (imem_ack always high):
//   FETCH  imem_req=1, ack sampled at the closing edge
//   DECODE irWrite=1, fields sampled and latched at the closing edge
//   EXEC   datapath strobes + pcWrite, instruction retires at the closing edge
// Memory instructions use EXEC only to launch the access; MEM holds dmem_req
// until dmem_ack or timeout. A completed store spends one FETCH cycle with
// pcWrite high before it requests the next instruction.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall               hold in FETCH with no request
//   format/opcode/sign  instruction fields, valid while irWrite is high
//   imem_ack, dmem_ack  memory handshake completions
//   imem_req, dmem_req  memory requests
//   irWrite, pcWrite, regWrite, writeSrc, memRead, memWrite
//                       datapath enables
//   cpin, cpout, branch, jump
//                       single-cycle operation pulses
//   halt, mem_err       sticky status (mem_err implies halt)
//   retired_cnt         retired instructions, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                format,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                sign,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                regWrite,
  output logic [1:0]          writeSrc,
  output logic                memRead,
  output logic                memWrite,
  output logic                cpin,
  output logic                cpout,
  output logic                branch,
  output logic                jump,
  output logic                halt,
  output logic                mem_err,
  output logic [CNT_W-1:0]    retired_cnt
);

  state_t             r_state;
  instr_class_t       r_class;
  logic               r_imemReq;
  logic               r_dmemReq;
  logic               r_irWrite;
  logic               r_pcWrite;
  logic               r_regWrite;
  logic [1:0]         r_writeSrc;
  logic               r_memRead;
  logic               r_memWrite;
  logic               r_cpin;
  logic               r_cpout;
  logic               r_branch;
  logic               r_jump;
  logic               r_halt;
  logic               r_memErr;
  logic [CNT_W-1:0]   r_retiredCnt;

  logic [31:0]        w_opWide;
  logic               w_opInRange;
  logic [3:0]         w_opLow;
  instr_class_t       w_class;
  logic               w_toEnable;
  logic               w_toClear;
  logic               w_toExpire;
  logic               w_retire;

  // Opcodes wider than four bits are only known when the upper bits are 0.
  assign w_opWide    = 32'(opcode);
  assign w_opInRange = (w_opWide < 32'd16);
  assign w_opLow     = w_opWide[3:0];
  assign w_class     = classifyInstr(format, w_opInRange, w_opLow, sign);

  // Timeout counter runs only while waiting in MEM and restarts whenever
  // MEM is left, either by acknowledge or by expiry.
  assign w_toEnable = (r_state == MEM);
  assign w_toClear  = w_toEnable && (dmem_ack || w_toExpire);

  ctrl_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clear  (w_toClear),
    .i_enable (w_toEnable),
    .o_expire (w_toExpire)
  );

  // An instruction retires at the edge that closes its pcWrite cycle; halt
  // never writes the PC and retires as it leaves EXEC.
  assign w_retire = r_pcWrite || ((r_state == EXEC) && (r_class == CLS_HALT));

  // Sequencer. Every strobe is computed for the state being entered, so
  // the outputs below are plain register copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_class      <= CLS_IMM;
      r_imemReq    <= 1'b0;
      r_dmemReq    <= 1'b0;
      r_irWrite    <= 1'b0;
      r_pcWrite    <= 1'b0;
      r_regWrite   <= 1'b0;
      r_writeSrc   <= WRITE_MEM;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
      r_cpin       <= 1'b0;
      r_cpout      <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_halt       <= 1'b0;
      r_memErr     <= 1'b0;
      r_retiredCnt <= '0;
    end else begin
      r_irWrite  <= 1'b0;
      r_pcWrite  <= 1'b0;
      r_regWrite <= 1'b0;
      r_writeSrc <= WRITE_MEM;
      r_cpin     <= 1'b0;
      r_cpout    <= 1'b0;
      r_branch   <= 1'b0;
      r_jump     <= 1'b0;

      if (w_retire) begin
        r_retiredCnt <= r_retiredCnt + CNT_W'(1);
      end

      case (r_state)
        FETCH: begin
          // Stall withdraws the request; an ack only counts against a
          // request that is actually on the bus.
          if (stall) begin
            r_imemReq <= 1'b0;
          end else if (r_imemReq && imem_ack) begin
            r_imemReq <= 1'b0;
            r_irWrite <= 1'b1;
            r_state   <= DECODE;
          end else begin
            r_imemReq <= 1'b1;
          end
        end

        DECODE: begin
          // The instruction register loads at this edge; take the decoded
          // class along with it and raise the EXEC strobes.
          r_class <= w_class;
          r_state <= EXEC;
          case (w_class)
            CLS_IMM: begin
              r_regWrite <= 1'b1;
              r_writeSrc <= WRITE_IMM;
              r_pcWrite  <= 1'b1;
            end
            CLS_ALU: begin
              r_regWrite <= 1'b1;
              r_writeSrc <= WRITE_ALU;
              r_pcWrite  <= 1'b1;
            end
            CLS_CPOUT: begin
              r_cpout   <= 1'b1;
              r_pcWrite <= 1'b1;
            end
            CLS_CPIN: begin
              r_cpin    <= 1'b1;
              r_pcWrite <= 1'b1;
            end
            CLS_BRANCH: begin
              r_branch  <= 1'b1;
              r_pcWrite <= 1'b1;
            end
            CLS_JUMP: begin
              r_jump    <= 1'b1;
              r_pcWrite <= 1'b1;
            end
            default: begin
            end
          endcase
        end

        EXEC: begin
          case (r_class)
            CLS_LOAD, CLS_EPAR: begin
              r_dmemReq <= 1'b1;
              r_memRead <= 1'b1;
              r_state   <= MEM;
            end
            CLS_STORE: begin
              r_dmemReq  <= 1'b1;
              r_memWrite <= 1'b1;
              r_state    <= MEM;
            end
            CLS_HALT: begin
              r_halt  <= 1'b1;
              r_state <= HALTED;
            end
            default: begin
              r_imemReq <= 1'b1;
              r_state   <= FETCH;
            end
          endcase
        end

        MEM: begin
          // An ack arriving on the expiry cycle still completes the access.
          if (dmem_ack) begin
            r_dmemReq  <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_pcWrite  <= 1'b1;
            if (r_class == CLS_STORE) begin
              r_state <= FETCH;
            end else begin
              r_regWrite <= 1'b1;
              r_writeSrc <= (r_class == CLS_LOAD) ? WRITE_MEM : WRITE_ALU;
              r_state    <= WB;
            end
          end else if (w_toExpire) begin
            r_dmemReq  <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_memErr   <= 1'b1;
            r_halt     <= 1'b1;
            r_state    <= HALTED;
          end
        end

        WB: begin
          r_imemReq <= 1'b1;
          r_state   <= FETCH;
        end

        HALTED: begin
        end

        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign imem_req    = r_imemReq;
  assign dmem_req    = r_dmemReq;
  assign irWrite     = r_irWrite;
  assign pcWrite     = r_pcWrite;
  assign regWrite    = r_regWrite;
  assign writeSrc    = r_writeSrc;
  assign memRead     = r_memRead;
  assign memWrite    = r_memWrite;
  assign cpin        = r_cpin;
  assign cpout       = r_cpout;
  assign branch      = r_branch;
  assign jump        = r_jump;
  assign halt        = r_halt;
  assign mem_err     = r_memErr;
  assign retired_cnt = r_retiredCnt;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control built with TIMEOUT_CYC=4 and CNT_W=2
// so the timeout and counter wrap are reached quickly. All outputs except
// retired_cnt are packed into one vector and compared against hand-built
// expectations; retired_cnt is compared against a wrapping model count.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       format;
  logic [3:0] opcode;
  logic       sign;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       dmem_req;
  logic       irWrite;
  logic       pcWrite;
  logic       regWrite;
  logic [1:0] writeSrc;
  logic       memRead;
  logic       memWrite;
  logic       cpin;
  logic       cpout;
  logic       branch;
  logic       jump;
  logic       halt;
  logic       mem_err;
  logic [1:0] retired_cnt;

  // Output vector bit assignments
  localparam logic [14:0] B_IMEM  = 15'h4000;
  localparam logic [14:0] B_DMEM  = 15'h2000;
  localparam logic [14:0] B_IR    = 15'h1000;
  localparam logic [14:0] B_PC    = 15'h0800;
  localparam logic [14:0] B_RW    = 15'h0400;
  localparam logic [14:0] SRC_IMM = 15'h0100;
  localparam logic [14:0] SRC_ALU = 15'h0300;
  localparam logic [14:0] SRC_MEM = 15'h0000;
  localparam logic [14:0] B_RD    = 15'h0080;
  localparam logic [14:0] B_WR    = 15'h0040;
  localparam logic [14:0] B_CPIN  = 15'h0020;
  localparam logic [14:0] B_CPOUT = 15'h0010;
  localparam logic [14:0] B_BR    = 15'h0008;
  localparam logic [14:0] B_JMP   = 15'h0004;
  localparam logic [14:0] B_HALT  = 15'h0002;
  localparam logic [14:0] B_ERR   = 15'h0001;

  logic [14:0] outVec;
  assign outVec = {imem_req, dmem_req, irWrite, pcWrite, regWrite, writeSrc,
                   memRead, memWrite, cpin, cpout, branch, jump, halt, mem_err};

  typedef struct {
    string       name;
    logic        fmt;
    logic [3:0]  op;
    logic        sg;
    logic [14:0] expExec;
  } vec_t;

  vec_t       vecs [8];
  int         checks;
  int         errors;
  logic [1:0] expCnt;

  multicycle_control #(
    .OPCODE_W    (4),
    .TIMEOUT_CYC (4),
    .CNT_W       (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .format      (format),
    .opcode      (opcode),
    .sign        (sign),
    .imem_ack    (imem_ack),
    .dmem_ack    (dmem_ack),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .irWrite     (irWrite),
    .pcWrite     (pcWrite),
    .regWrite    (regWrite),
    .writeSrc    (writeSrc),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .cpin        (cpin),
    .cpout       (cpout),
    .branch      (branch),
    .jump        (jump),
    .halt        (halt),
    .mem_err     (mem_err),
    .retired_cnt (retired_cnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stops advancing
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock; outputs are inspected and inputs driven 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fmt, input logic [3:0] op,
                               input logic sg, input logic iack,
                               input logic dack);
    format   = fmt;
    opcode   = op;
    sign     = sg;
    imem_ack = iack;
    dmem_ack = dack;
  endtask

  task automatic checkOutput(input string name, input logic [14:0] expVec);
    checks++;
    if (outVec !== expVec) begin
      errors++;
      $display("[TB] FAIL %s: outputs %h, expected %h", name, outVec, expVec);
    end
  endtask

  task automatic checkCount(input string name);
    checks++;
    if (retired_cnt !== expCnt) begin
      errors++;
      $display("[TB] FAIL %s: retired_cnt %0d, expected %0d", name, retired_cnt, expCnt);
    end
  endtask

  // From a FETCH cycle with the request up: fetch, decode, then spend
  // ackCycle+1 cycles in MEM, acknowledging on the last of them. Returns on
  // the cycle after the acknowledge.
  task automatic memInstr(input string name, input logic [3:0] op,
                          input int ackCycle, input logic isRead);
    applyStimulus(1'b1, op, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput({name, " decode"}, B_IR);
    tick();
    checkOutput({name, " exec"}, 15'h0000);
    for (int m = 0; m <= ackCycle; m++) begin
      tick();
      checkOutput($sformatf("%s mem%0d", name, m), B_DMEM | (isRead ? B_RD : B_WR));
      if (m == ackCycle) dmem_ack = 1'b1;
    end
    tick();
    dmem_ack = 1'b0;
  endtask

  // Main sequence
  initial begin
    checks = 0;
    errors = 0;
    expCnt = 2'd0;

    vecs[0] = '{"add",           1'b1, 4'b0000, 1'b0, B_PC | B_RW | SRC_ALU};
    vecs[1] = '{"fmt0 halt op",  1'b0, 4'b1011, 1'b0, B_PC | B_RW | SRC_IMM};
    vecs[2] = '{"cp sign1",      1'b1, 4'b0111, 1'b1, B_PC | B_CPOUT};
    vecs[3] = '{"cp sign0",      1'b1, 4'b0111, 1'b0, B_PC | B_CPIN};
    vecs[4] = '{"branch",        1'b1, 4'b0100, 1'b0, B_PC | B_BR};
    vecs[5] = '{"jump",          1'b1, 4'b0011, 1'b1, B_PC | B_JMP};
    vecs[6] = '{"unknown 1111",  1'b1, 4'b1111, 1'b0, B_PC | B_RW | SRC_IMM};
    vecs[7] = '{"unknown 0110",  1'b1, 4'b0110, 1'b0, B_PC | B_RW | SRC_IMM};

    // Reset state and first immediate instruction
    rst_n = 1'b0;
    stall = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("in reset", 15'h0000);
    checkCount("in reset");
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkOutput("after reset", 15'h0000);
    tick();
    checkOutput("first fetch", B_IMEM);
    tick();
    checkOutput("first decode", B_IR);
    tick();
    checkOutput("first exec", B_PC | B_RW | SRC_IMM);
    checkCount("before first retire");
    tick();
    expCnt = expCnt + 2'd1;
    checkOutput("second fetch", B_IMEM);
    checkCount("first retire");

    // Single-cycle instructions from the table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].fmt, vecs[i].op, vecs[i].sg, 1'b1, 1'b0);
      tick();
      checkOutput({vecs[i].name, " decode"}, B_IR);
      tick();
      checkOutput({vecs[i].name, " exec"}, vecs[i].expExec);
      tick();
      expCnt = expCnt + 2'd1;
      checkOutput({vecs[i].name, " next fetch"}, B_IMEM);
      checkCount({vecs[i].name, " count"});
    end

    // Load, acknowledged two cycles after the request
    memInstr("load", 4'b0001, 2, 1'b1);
    checkOutput("load wb", B_PC | B_RW | SRC_MEM);
    tick();
    expCnt = expCnt + 2'd1;
    checkOutput("load next fetch", B_IMEM);
    checkCount("load count");

    // epar, acknowledged immediately, writes back from the ALU
    memInstr("epar", 4'b0101, 0, 1'b1);
    checkOutput("epar wb", B_PC | B_RW | SRC_ALU);
    tick();
    expCnt = expCnt + 2'd1;
    checkOutput("epar next fetch", B_IMEM);
    checkCount("epar count");

    // Store acked after one wait: counter wraps to 0 here
    memInstr("store", 4'b0010, 1, 1'b0);
    checkOutput("store pc cycle", B_PC);
    tick();
    expCnt = expCnt + 2'd1;
    checkOutput("store next fetch", B_IMEM);
    checkCount("store count wrap");

    // Store acked on the fourth MEM cycle: ack beats the timeout
    memInstr("store late ack", 4'b0010, 3, 1'b0);
    checkOutput("store late ack pc cycle", B_PC);
    tick();
    expCnt = expCnt + 2'd1;
    checkOutput("store late ack next fetch", B_IMEM);
    checkCount("store late ack count");

    // Reset while a load waits in MEM clears everything immediately
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("abort load mem0", B_DMEM | B_RD);
    tick();
    rst_n = 1'b0;
    #1;
    expCnt = 2'd0;
    checkOutput("reset mid mem", 15'h0000);
    checkCount("reset mid mem");

    // Stall for five cycles after reset, then a halt opcode
    stall = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      checkOutput($sformatf("stall %0d", s), 15'h0000);
    end
    stall = 1'b0;
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("halt fetch", B_IMEM);
    tick();
    checkOutput("halt decode", B_IR);
    tick();
    checkOutput("halt exec", 15'h0000);
    tick();
    expCnt = expCnt + 2'd1;
    checkOutput("halted", B_HALT);
    checkCount("halt retire");
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int h = 0; h < 3; h++) begin
      tick();
      checkOutput($sformatf("halt sticky %0d", h), B_HALT);
      checkCount($sformatf("halt frozen %0d", h));
    end

    // Store that is never acknowledged times out after four MEM cycles
    rst_n = 1'b0;
    #1;
    expCnt = 2'd0;
    checkOutput("second reset", 15'h0000);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("timeout fetch", B_IMEM);
    tick();
    checkOutput("timeout decode", B_IR);
    tick();
    checkOutput("timeout exec", 15'h0000);
    for (int m = 0; m < 4; m++) begin
      tick();
      checkOutput($sformatf("timeout mem%0d", m), B_DMEM | B_WR);
    end
    tick();
    checkOutput("timeout error", B_HALT | B_ERR);
    checkCount("timeout no retire");
    dmem_ack = 1'b1;
    for (int h = 0; h < 2; h++) begin
      tick();
      checkOutput($sformatf("late ack ignored %0d", h), B_HALT | B_ERR);
    end
    checkCount("timeout count frozen");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
